wb_trace_checker: RTL and testbench
===================================

Name: wb_trace_checker

Overview:
- Synthesizable self-checking monitor for the Abejaruco core, fed by the register-file write-back port (enable, index, data).
- Compares each architectural register write against a preloaded expected trace of up to TRACE_DEPTH entries, in order.
- Reports pass, fail or timeout, with latched failure details.
- Replaces hand-counted clock loops and $display checks in top-level benches; can also be instantiated on-chip for bring-up.

Parameters:
- WORD_WIDTH, 32, width of write-back data.
- REG_IDX_WIDTH, 5, width of register index.
- TRACE_DEPTH, 16, number of expected-trace entries; power of two, at least 2.
- TIMEOUT_CYCLES, 64, maximum RUN cycles allowed between consecutive counted writes.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- load_en  in  1  write one trace entry this cycle.
- load_addr  in  $clog2(TRACE_DEPTH)  trace entry to write.
- load_idx  in  REG_IDX_WIDTH  expected destination register.
- load_data  in  WORD_WIDTH  expected write data.
- num_expected  in  $clog2(TRACE_DEPTH)+1  trace length, sampled on start.
- start  in  1  arm the check.
- rf_write_enable  in  1  core write-back enable.
- rf_write_idx  in  REG_IDX_WIDTH  core write-back register.
- rf_write_data  in  WORD_WIDTH  core write-back data.
- busy  out  1  state is RUN.
- done  out  1  state is PASS or FAIL.
- pass  out  1  state is PASS.
- timeout  out  1  the failure was caused by timeout.
- match_count  out  $clog2(TRACE_DEPTH)+1  number of matched writes.
- fail_ptr  out  $clog2(TRACE_DEPTH)  trace entry that failed.
- fail_idx  out  REG_IDX_WIDTH  register index received on the failing write.
- fail_data  out  WORD_WIDTH  data received on the failing write.

Behaviour:
- States: IDLE, RUN, PASS, FAIL.
- Reset:
  - state goes to IDLE; all outputs, the trace pointer and the timeout counter go to 0.
  - Trace memory is not cleared and keeps its contents across reset.
- Loading:
  - load_en writes {load_idx, load_data} to entry load_addr on the clock edge.
  - Accepted in IDLE, PASS and FAIL; ignored in RUN.
- start in IDLE, PASS or FAIL:
  - clears pointer, match_count, timeout counter and all fail_* outputs.
  - Latches len = min(num_expected, TRACE_DEPTH).
  - len == 0: go to PASS next cycle. Otherwise go to RUN.
  - start while in RUN is ignored.
- Counted write: a RUN-state cycle with rf_write_enable=1 and rf_write_idx != 0. Writes to x0 are ignored.
- Match: {rf_write_idx, rf_write_data} equals trace[ptr].
  - ptr increments, match_count increments, timeout counter clears.
  - If this was the last entry (ptr == len-1): go to PASS.
- Mismatch:
  - go to FAIL.
  - Latch fail_ptr=ptr, fail_idx=rf_write_idx, fail_data=rf_write_data; timeout=0.
- Timeout counter:
  - increments every RUN cycle without a counted write.
  - On the cycle it would reach TIMEOUT_CYCLES: go to FAIL with timeout=1, fail_ptr=ptr, fail_idx=0, fail_data=0.
  - A counted write in that same cycle takes priority; the timeout does not fire.
- Latency: every status output is registered and reflects the decision one cycle after the deciding write-back cycle.
- Write-back inputs in IDLE, PASS and FAIL are ignored.
- reset asserted during RUN aborts the check: IDLE next cycle, no PASS or FAIL is reported.
- Reading and writing the same entry in one cycle cannot occur, because loads are blocked in RUN.

Decomposition:
- Shared include (abejaruco_defs.v): WORD_WIDTH, REG_IDX_WIDTH, and the 2-bit state encodings IDLE=0, RUN=1, PASS=2, FAIL=3.
- One sub-module, trace_ram:
  - TRACE_DEPTH x (REG_IDX_WIDTH+WORD_WIDTH) storage.
  - Synchronous write, asynchronous read.
  - No reset.
- The FSM and counters stay in wb_trace_checker.

Test Plan:
1. Load entry0={x2, 0xFFFFFFFC}, num_expected=1, start; drive write x2/0xFFFFFFFC three cycles later -> pass=1, done=1, match_count=1 one cycle after the write.
2. Load 3 entries {x1,0x1},{x3,0x5},{x4,0xA}; drive x1/0x1, x0/0xDEAD, x3/0x5, x4/0xA -> x0 write ignored, PASS, match_count=3.
3. Same trace; drive x1/0x1 then x3/0x6 -> FAIL, timeout=0, fail_ptr=1, fail_idx=3, fail_data=0x6, match_count=1.
4. TIMEOUT_CYCLES=64, len=2; one matching write, then idle -> FAIL exactly 64 RUN cycles after that write, timeout=1, fail_ptr=1. Repeat with a matching write on cycle 64 -> no timeout; that write counts as a match, giving PASS.
5. num_expected=0, start -> PASS on the next cycle, match_count=0. num_expected=20 with TRACE_DEPTH=16 -> len clamps to 16; PASS after 16 matches.
6. Reset mid-RUN after 1 match -> next cycle IDLE, all outputs 0; a restart without reloading passes on the previously loaded trace (memory preserved). A load_en issued during RUN does not alter any trace entry.

Source files
------------

// File: rtl/wb_trace_checker_pkg.sv
// Shared definitions for the Abejaruco write-back trace checker.
//   - default data / register-index widths of the core's register-file port
//   - 2-bit checker state encodings (IDLE=0, RUN=1, PASS=2, FAIL=3)
package wb_trace_checker_pkg;

   localparam int unsigned DefWordWidth   = 32;
   localparam int unsigned DefRegIdxWidth = 5;

   typedef logic [1:0] state_t;

   localparam state_t StIdle = 2'd0;
   localparam state_t StRun  = 2'd1;
   localparam state_t StPass = 2'd2;
   localparam state_t StFail = 2'd3;

endpackage

// File: rtl/wb_trace_checker_trace_ram.sv
// Expected-trace storage: DEPTH entries of {register index, write data}.
// Synchronous write, asynchronous read, no reset (contents survive reset).
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   entry to write
//   wdata  in   {idx, data} to store
//   raddr  in   entry to read
//   rdata  out  {idx, data} stored at raddr (combinational)
module wb_trace_checker_trace_ram #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 37
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_checker.sv
// Write-back trace checker for the Abejaruco core.
// Watches the register-file write-back port and compares every architectural
// register write (writes to x0 excluded) against a preloaded expected trace,
// in order. Reports pass, fail (with the offending write latched) or timeout.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   load_en/addr/idx/data write one expected-trace entry (not in RUN)
//   num_expected          trace length, sampled on start (clamped to TRACE_DEPTH)
//   start                 arm the check (ignored in RUN)
//   rf_write_enable/idx/data  core write-back port under observation
//   busy, done, pass      status: RUN, PASS or FAIL, PASS
//   timeout               failure caused by too long a gap between writes
//   match_count           writes matched so far
//   fail_ptr/idx/data     entry that failed and the write received for it
module wb_trace_checker
   import wb_trace_checker_pkg::*;
#(
   parameter int unsigned WORD_WIDTH     = DefWordWidth,
   parameter int unsigned REG_IDX_WIDTH  = DefRegIdxWidth,
   parameter int unsigned TRACE_DEPTH    = 16,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           load_en,
   input  logic [$clog2(TRACE_DEPTH)-1:0] load_addr,
   input  logic [REG_IDX_WIDTH-1:0]       load_idx,
   input  logic [WORD_WIDTH-1:0]          load_data,
   input  logic [$clog2(TRACE_DEPTH):0]   num_expected,
   input  logic                           start,
   input  logic                           rf_write_enable,
   input  logic [REG_IDX_WIDTH-1:0]       rf_write_idx,
   input  logic [WORD_WIDTH-1:0]          rf_write_data,
   output logic                           busy,
   output logic                           done,
   output logic                           pass,
   output logic                           timeout,
   output logic [$clog2(TRACE_DEPTH):0]   match_count,
   output logic [$clog2(TRACE_DEPTH)-1:0] fail_ptr,
   output logic [REG_IDX_WIDTH-1:0]       fail_idx,
   output logic [WORD_WIDTH-1:0]          fail_data
);

   localparam int unsigned PW = $clog2(TRACE_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned EW = REG_IDX_WIDTH + WORD_WIDTH;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CW-1:0] DepthLen = CW'(TRACE_DEPTH);
   // Counter value at which one more quiet cycle would reach TIMEOUT_CYCLES.
   localparam logic [TW-1:0] TmoLast  = TW'(TIMEOUT_CYCLES - 1);

   state_t                   state_q, state_d;
   logic [PW-1:0]            ptr_q, ptr_d;
   logic [CW-1:0]            len_q, len_d;
   logic [CW-1:0]            match_q, match_d;
   logic [TW-1:0]            tmo_q, tmo_d;
   logic                     timeout_q, timeout_d;
   logic [PW-1:0]            fail_ptr_q, fail_ptr_d;
   logic [REG_IDX_WIDTH-1:0] fail_idx_q, fail_idx_d;
   logic [WORD_WIDTH-1:0]    fail_data_q, fail_data_d;

   logic                     ram_we;
   logic [EW-1:0]            ram_rdata;
   logic [REG_IDX_WIDTH-1:0] exp_idx;
   logic [WORD_WIDTH-1:0]    exp_data;
   logic [CW-1:0]            start_len;
   logic                     counted;
   logic                     hit;
   logic                     last;

   // Loads are blocked while checking, so the entry under comparison is stable.
   assign ram_we = load_en && (state_q != StRun);

   wb_trace_checker_trace_ram #(
      .DEPTH (TRACE_DEPTH),
      .WIDTH (EW)
   ) u_trace_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (load_addr),
      .wdata ({load_idx, load_data}),
      .raddr (ptr_q),
      .rdata (ram_rdata)
   );

   assign exp_idx  = ram_rdata[EW-1:WORD_WIDTH];
   assign exp_data = ram_rdata[WORD_WIDTH-1:0];

   assign start_len = (num_expected > DepthLen) ? DepthLen : num_expected;
   assign counted   = rf_write_enable && (rf_write_idx != '0);
   assign hit       = (rf_write_idx == exp_idx) && (rf_write_data == exp_data);
   assign last      = ({1'b0, ptr_q} == (len_q - CW'(1)));

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      len_d       = len_q;
      match_d     = match_q;
      tmo_d       = tmo_q;
      timeout_d   = timeout_q;
      fail_ptr_d  = fail_ptr_q;
      fail_idx_d  = fail_idx_q;
      fail_data_d = fail_data_q;

      case (state_q)
         StRun: begin
            if (counted) begin
               if (hit) begin
                  ptr_d   = ptr_q + PW'(1);
                  match_d = match_q + CW'(1);
                  tmo_d   = '0;
                  if (last) begin
                     state_d = StPass;
                  end
               end else begin
                  state_d     = StFail;
                  timeout_d   = 1'b0;
                  fail_ptr_d  = ptr_q;
                  fail_idx_d  = rf_write_idx;
                  fail_data_d = rf_write_data;
               end
            end else if (tmo_q == TmoLast) begin
               state_d     = StFail;
               timeout_d   = 1'b1;
               fail_ptr_d  = ptr_q;
               fail_idx_d  = '0;
               fail_data_d = '0;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: begin
            // IDLE, PASS and FAIL all accept a new start.
            if (start) begin
               ptr_d       = '0;
               match_d     = '0;
               tmo_d       = '0;
               timeout_d   = 1'b0;
               fail_ptr_d  = '0;
               fail_idx_d  = '0;
               fail_data_d = '0;
               len_d       = start_len;
               state_d     = (start_len == '0) ? StPass : StRun;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         len_q       <= '0;
         match_q     <= '0;
         tmo_q       <= '0;
         timeout_q   <= 1'b0;
         fail_ptr_q  <= '0;
         fail_idx_q  <= '0;
         fail_data_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         len_q       <= len_d;
         match_q     <= match_d;
         tmo_q       <= tmo_d;
         timeout_q   <= timeout_d;
         fail_ptr_q  <= fail_ptr_d;
         fail_idx_q  <= fail_idx_d;
         fail_data_q <= fail_data_d;
      end
   end

   assign busy        = (state_q == StRun);
   assign done        = (state_q == StPass) || (state_q == StFail);
   assign pass        = (state_q == StPass);
   assign timeout     = timeout_q;
   assign match_count = match_q;
   assign fail_ptr    = fail_ptr_q;
   assign fail_idx    = fail_idx_q;
   assign fail_data   = fail_data_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Bench for wb_trace_checker: directed stimulus, a cycle-level behavioural
// model compared against the DUT on every cycle, plus literal expectations.
module tb_wb_trace_checker;

   localparam int TD = 16;
   localparam int PW = 4;
   localparam int CW = 5;
   localparam int WW = 32;
   localparam int IW = 5;
   localparam int TO = 64;

   bit clk;
   initial forever #5 clk = ~clk;

   logic          reset;
   logic          load_en;
   logic [PW-1:0] load_addr;
   logic [IW-1:0] load_idx;
   logic [WW-1:0] load_data;
   logic [CW-1:0] num_expected;
   logic          start;
   logic          rf_write_enable;
   logic [IW-1:0] rf_write_idx;
   logic [WW-1:0] rf_write_data;
   logic          busy, done, pass, timeout;
   logic [CW-1:0] match_count;
   logic [PW-1:0] fail_ptr;
   logic [IW-1:0] fail_idx;
   logic [WW-1:0] fail_data;

   wb_trace_checker #(
      .WORD_WIDTH     (WW),
      .REG_IDX_WIDTH  (IW),
      .TRACE_DEPTH    (TD),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .load_en         (load_en),
      .load_addr       (load_addr),
      .load_idx        (load_idx),
      .load_data       (load_data),
      .num_expected    (num_expected),
      .start           (start),
      .rf_write_enable (rf_write_enable),
      .rf_write_idx    (rf_write_idx),
      .rf_write_data   (rf_write_data),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .timeout         (timeout),
      .match_count     (match_count),
      .fail_ptr        (fail_ptr),
      .fail_idx        (fail_idx),
      .fail_data       (fail_data)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs as seen by the DUT at the most recent rising edge.
   logic          s_reset, s_load_en, s_start, s_wen;
   logic [PW-1:0] s_load_addr;
   logic [IW-1:0] s_load_idx, s_widx;
   logic [WW-1:0] s_load_data, s_wdata;
   logic [CW-1:0] s_num;

   always @(posedge clk) begin
      s_reset     <= reset;
      s_load_en   <= load_en;
      s_load_addr <= load_addr;
      s_load_idx  <= load_idx;
      s_load_data <= load_data;
      s_num       <= num_expected;
      s_start     <= start;
      s_wen       <= rf_write_enable;
      s_widx      <= rf_write_idx;
      s_wdata     <= rf_write_data;
   end

   // Behavioural model: what the checker must report after each edge.
   typedef enum {MIdle, MRun, MPass, MFail} mphase_e;
   mphase_e       m_phase;
   logic [IW-1:0] m_idx [TD];
   logic [WW-1:0] m_data [TD];
   int            m_len, m_ptr, m_quiet, m_match, m_fail_ptr;
   bit            m_timeout;
   logic [IW-1:0] m_fail_idx;
   logic [WW-1:0] m_fail_data;
   bit            model_valid = 0;

   task automatic model_clear();
      m_ptr = 0; m_quiet = 0; m_match = 0; m_timeout = 0;
      m_fail_ptr = 0; m_fail_idx = '0; m_fail_data = '0;
   endtask

   task automatic model_step();
      if (s_reset === 1'b1) begin
         m_phase = MIdle; m_len = 0;
         model_clear();
         model_valid = 1;
      end else if (model_valid) begin
         if (m_phase != MRun) begin
            if (s_load_en) begin
               m_idx[s_load_addr]  = s_load_idx;
               m_data[s_load_addr] = s_load_data;
            end
            if (s_start) begin
               model_clear();
               m_len   = (int'(s_num) > TD) ? TD : int'(s_num);
               m_phase = (m_len == 0) ? MPass : MRun;
            end
         end else if (s_wen && s_widx != '0) begin
            if (s_widx == m_idx[m_ptr] && s_wdata == m_data[m_ptr]) begin
               m_ptr++; m_match++; m_quiet = 0;
               if (m_ptr == m_len) m_phase = MPass;
            end else begin
               m_phase = MFail; m_timeout = 0; m_fail_ptr = m_ptr;
               m_fail_idx = s_widx; m_fail_data = s_wdata;
            end
         end else begin
            m_quiet++;
            if (m_quiet == TO) begin
               m_phase = MFail; m_timeout = 1; m_fail_ptr = m_ptr;
               m_fail_idx = '0; m_fail_data = '0;
            end
         end
      end
   endtask

   initial forever begin
      @(negedge clk);
      model_step();
      if (model_valid) begin
         check("busy",        64'(busy),        64'(m_phase == MRun));
         check("done",        64'(done),        64'(m_phase == MPass || m_phase == MFail));
         check("pass",        64'(pass),        64'(m_phase == MPass));
         check("timeout",     64'(timeout),     64'(m_timeout));
         check("match_count", 64'(match_count), 64'(m_match));
         check("fail_ptr",    64'(fail_ptr),    64'(m_fail_ptr));
         check("fail_idx",    64'(fail_idx),    64'(m_fail_idx));
         check("fail_data",   64'(fail_data),   64'(m_fail_data));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int addr, input int idx, input logic [WW-1:0] data);
      load_en = 1; load_addr = PW'(addr); load_idx = IW'(idx); load_data = data;
      tick();
      load_en = 0;
   endtask

   task automatic arm(input int n);
      num_expected = CW'(n); start = 1;
      tick();
      start = 0;
   endtask

   task automatic wb(input int idx, input logic [WW-1:0] data);
      rf_write_enable = 1; rf_write_idx = IW'(idx); rf_write_data = data;
      tick();
      rf_write_enable = 0; rf_write_idx = '0; rf_write_data = '0;
   endtask

   initial begin
      reset = 1; load_en = 0; load_addr = '0; load_idx = '0; load_data = '0;
      num_expected = '0; start = 0;
      rf_write_enable = 0; rf_write_idx = '0; rf_write_data = '0;
      tick(); tick();
      reset = 0;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_match", 64'(match_count), 64'd0);

      // Single negative value, written three cycles after start.
      load(0, 2, 32'hFFFF_FFFC);
      arm(1);
      tick(); tick();
      wb(2, 32'hFFFF_FFFC);
      check("t1_pass", 64'(pass), 64'd1);
      check("t1_done", 64'(done), 64'd1);
      check("t1_match", 64'(match_count), 64'd1);

      // Three entries with an interleaved x0 write that must be ignored.
      load(0, 1, 32'h1); load(1, 3, 32'h5); load(2, 4, 32'hA);
      arm(3);
      wb(1, 32'h1); wb(0, 32'hDEAD); wb(3, 32'h5);
      check("t2_busy_mid", 64'(busy), 64'd1);
      wb(4, 32'hA);
      check("t2_pass", 64'(pass), 64'd1);
      check("t2_match", 64'(match_count), 64'd3);

      // Data mismatch on the second entry.
      arm(3);
      wb(1, 32'h1); wb(3, 32'h6);
      check("t3_done", 64'(done), 64'd1);
      check("t3_pass", 64'(pass), 64'd0);
      check("t3_timeout", 64'(timeout), 64'd0);
      check("t3_fail_ptr", 64'(fail_ptr), 64'd1);
      check("t3_fail_idx", 64'(fail_idx), 64'd3);
      check("t3_fail_data", 64'(fail_data), 64'h6);
      check("t3_match", 64'(match_count), 64'd1);

      // Timeout fires on the 64th quiet RUN cycle after a match.
      load(0, 5, 32'h55); load(1, 6, 32'h66);
      arm(2);
      wb(5, 32'h55);
      repeat (TO - 1) tick();
      check("t4_busy_63", 64'(busy), 64'd1);
      tick();
      check("t4_done", 64'(done), 64'd1);
      check("t4_timeout", 64'(timeout), 64'd1);
      check("t4_fail_ptr", 64'(fail_ptr), 64'd1);
      check("t4_fail_idx", 64'(fail_idx), 64'd0);
      // A write landing on that 64th cycle wins over the timeout.
      arm(2);
      wb(5, 32'h55);
      repeat (TO - 1) tick();
      wb(6, 32'h66);
      check("t4b_pass", 64'(pass), 64'd1);
      check("t4b_timeout", 64'(timeout), 64'd0);
      check("t4b_match", 64'(match_count), 64'd2);

      // Empty trace, then an over-long length clamped to the depth.
      arm(0);
      check("t5_pass0", 64'(pass), 64'd1);
      check("t5_match0", 64'(match_count), 64'd0);
      for (int i = 0; i < TD; i++) load(i, i + 1, 32'h1000_0000 + 32'(i) * 32'h111);
      arm(20);
      for (int i = 0; i < TD; i++) wb(i + 1, 32'h1000_0000 + 32'(i) * 32'h111);
      check("t5_pass16", 64'(pass), 64'd1);
      check("t5_match16", 64'(match_count), 64'd16);

      // Reset mid-RUN, load attempt during RUN, then rerun on kept memory.
      arm(3);
      wb(1, 32'h1000_0000);
      load(1, 7, 32'hBAD0_BAD0);
      reset = 1;
      tick();
      reset = 0;
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_done", 64'(done), 64'd0);
      check("t6_pass", 64'(pass), 64'd0);
      check("t6_match", 64'(match_count), 64'd0);
      arm(3);
      wb(1, 32'h1000_0000); wb(2, 32'h1000_0111); wb(3, 32'h1000_0222);
      check("t6_pass_rerun", 64'(pass), 64'd1);
      check("t6_match_rerun", 64'(match_count), 64'd3);

      tick(); tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
